// File: rtl/ahb_fir_cfg_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_fir_cfg_slave_if
// Brief    : AHB-lite style bus bundle for the FIR configuration slave.
// Revision : 1.0
// ============================================================================
interface ahb_fir_cfg_slave_if #(
    parameter int DATA_BYTES = 2,
    parameter int ADDR_WIDTH = 4
);
    logic                    hsel;
    logic [1:0]              htrans;
    logic [ADDR_WIDTH-1:0]   haddr;
    logic [1:0]              hsize;
    logic                    hwrite;
    logic [8*DATA_BYTES-1:0] hwdata;
    logic [8*DATA_BYTES-1:0] hrdata;
    logic                    hresp;

    modport master (
        output hsel, htrans, haddr, hsize, hwrite, hwdata,
        input  hrdata, hresp
    );

    modport slave (
        input  hsel, htrans, haddr, hsize, hwrite, hwdata,
        output hrdata, hresp
    );
endinterface
`default_nettype wire

// File: rtl/ahb_fir_cfg_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_fir_cfg_slave
// Brief    : AHB slave holding FIR coefficients, a sample FIFO and status.
// Revision : 1.0
// ============================================================================
module ahb_fir_cfg_slave #(
    parameter int DATA_BYTES = 2,
    parameter int NUM_COEFF  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    ahb_fir_cfg_slave_if.slave           bus,
    input  logic [8*DATA_BYTES-1:0]      fir_out,
    input  logic                         modwait,
    input  logic                         err,
    output logic [8*DATA_BYTES-1:0]      sample_data,
    output logic                         data_ready,
    output logic [8*DATA_BYTES-1:0]      fir_coefficient,
    output logic                         new_coefficient_set,
    input  logic [$clog2(NUM_COEFF)-1:0] coefficient_num
);
    localparam int C_DW         = 8 * DATA_BYTES;
    localparam int C_LANE_W     = $clog2(DATA_BYTES);
    localparam int C_CNUM_W     = $clog2(NUM_COEFF);
    localparam int C_PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int C_REG_STATUS = 0;
    localparam int C_REG_RESULT = 1;
    localparam int C_REG_SAMPLE = 2;
    localparam int C_REG_COEF0  = 3;
    localparam int C_REG_CSET   = 3 + NUM_COEFF;

    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_write;

    logic [C_DW-1:0]       r_coeff [NUM_COEFF];
    logic [C_DW-1:0]       r_mem   [FIFO_DEPTH];
    logic [C_PTR_W-1:0]    r_wptr;
    logic [C_PTR_W-1:0]    r_rptr;
    logic [3:0]            r_count;
    logic                  r_data_ready;
    logic [C_DW-1:0]       r_sample;
    logic                  r_ncs;
    logic                  r_modwait_d;

    logic                  w_accept;
    int                    w_idx;
    int                    w_off;
    int                    w_bytes;
    logic                  w_size_ok;
    logic                  w_align_ok;
    logic                  w_full;
    logic                  w_error;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_cset;
    logic                  w_ncs_clr;
    logic [DATA_BYTES-1:0] w_lane;
    logic [C_DW-1:0]       w_bmask;
    logic [C_DW-1:0]       w_status;
    logic [C_DW-1:0]       w_coef_rd;
    logic [C_DW-1:0]       w_rdata;
    logic [C_DW-1:0]       w_fir_coef;

    assign w_accept = bus.hsel && (bus.htrans == 2'b10 || bus.htrans == 2'b11);

    // Address phase register; cleared by reset so a pending transfer is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_size  <= '0;
            r_write <= 1'b0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_addr  <= bus.haddr;
                r_size  <= bus.hsize;
                r_write <= bus.hwrite;
            end
        end
    end

    always_comb begin
        w_idx      = int'(r_addr >> C_LANE_W);
        w_off      = int'(r_addr[C_LANE_W-1:0]);
        w_bytes    = 1 << r_size;
        w_size_ok  = (w_bytes <= DATA_BYTES);
        w_align_ok = ((int'(r_addr) & (w_bytes - 1)) == 0);
        w_full     = (w_bytes == DATA_BYTES);
        w_lane     = '0;
        w_bmask    = '0;
        for (int b = 0; b < DATA_BYTES; b++) begin
            w_lane[b]          = (b >= w_off) && (b < w_off + w_bytes);
            w_bmask[8*b +: 8]  = {8{w_lane[b]}};
        end

        w_error = 1'b0;
        if (!w_size_ok || !w_align_ok || (w_idx > C_REG_CSET)) begin
            w_error = 1'b1;
        end else if (r_write) begin
            if (w_idx == C_REG_STATUS || w_idx == C_REG_RESULT) begin
                w_error = 1'b1;
            end else if (w_idx == C_REG_SAMPLE) begin
                w_error = !w_full || (r_count == 4'(FIFO_DEPTH));
            end else if (w_idx < C_REG_CSET) begin
                w_error = r_ncs;
            end
        end else if (w_idx == C_REG_SAMPLE) begin
            w_error = 1'b1;
        end

        w_wr_ok = r_valid && r_write && !w_error;
        w_rd_ok = r_valid && !r_write && !w_error;
        w_push  = w_wr_ok && (w_idx == C_REG_SAMPLE);
        w_pop   = (|r_count) && !modwait && !r_data_ready;
        w_cset  = w_wr_ok && (w_idx == C_REG_CSET) && w_lane[0] && bus.hwdata[0];
    end

    assign w_ncs_clr = r_modwait_d && !modwait &&
                       (coefficient_num == C_CNUM_W'(NUM_COEFF - 1));

    // Coefficient writes commit at the end of the data phase, so a read whose
    // data phase follows directly already sees the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_COEFF; i++) begin
                r_coeff[i] <= '0;
            end
        end else if (w_wr_ok) begin
            for (int i = 0; i < NUM_COEFF; i++) begin
                if (w_idx == C_REG_COEF0 + i) begin
                    r_coeff[i] <= (r_coeff[i] & ~w_bmask) | (bus.hwdata & w_bmask);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.hwdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_data_ready <= 1'b0;
            r_sample     <= '0;
        end else begin
            r_data_ready <= w_pop;
            if (w_push) begin
                r_wptr <= (r_wptr == C_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_sample <= r_mem[r_rptr];
                r_rptr   <= (r_rptr == C_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A fresh coefficient set takes priority over a simultaneous release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ncs       <= 1'b0;
            r_modwait_d <= 1'b0;
        end else begin
            r_modwait_d <= modwait;
            if (w_cset) begin
                r_ncs <= 1'b1;
            end else if (w_ncs_clr) begin
                r_ncs <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status       = '0;
        w_status[0]    = modwait | r_ncs | (|r_count);
        w_status[1]    = err;
        w_status[7:4]  = r_count;
        w_coef_rd      = '0;
        w_fir_coef     = '0;
        for (int i = 0; i < NUM_COEFF; i++) begin
            if (w_idx == C_REG_COEF0 + i) begin
                w_coef_rd = r_coeff[i];
            end
            if (int'(coefficient_num) == i) begin
                w_fir_coef = r_coeff[i];
            end
        end

        w_rdata = '0;
        if (w_rd_ok) begin
            if (w_idx == C_REG_STATUS) begin
                w_rdata = w_status;
            end else if (w_idx == C_REG_RESULT) begin
                w_rdata = fir_out;
            end else if (w_idx == C_REG_CSET) begin
                w_rdata = {{(C_DW-1){1'b0}}, r_ncs};
            end else begin
                w_rdata = w_coef_rd;
            end
        end
    end

    assign bus.hrdata          = w_rdata;
    assign bus.hresp           = r_valid && w_error;
    assign sample_data         = r_sample;
    assign data_ready          = r_data_ready;
    assign new_coefficient_set = r_ncs;
    assign fir_coefficient     = w_fir_coef;

endmodule
`default_nettype wire
